// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_pkg;

    localparam int ADDR_W         = 6;
    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_WORDS     = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: shifts accepted bytes in MSB first and
// flags the byte that completes a word.
module word_assembler #(
    parameter int BYTES_PER_WORD = imem_pkg::BYTES_PER_WORD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_next_o,
    output logic        word_full_o
);

    logic [31:0] word_q;
    logic [1:0]  byte_cnt_q;

    // Next assembled word and completion flag for the byte on the input.
    always_comb begin
        word_next_o = {word_q[23:0], byte_i};
        word_full_o = accept_i && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    end

    // Shift register and byte counter; counter wraps naturally at each word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q     <= 32'd0;
            byte_cnt_q <= 2'd0;
        end else if (clr_i) begin
            word_q     <= 32'd0;
            byte_cnt_q <= 2'd0;
        end else if (accept_i) begin
            word_q     <= word_next_o;
            byte_cnt_q <= byte_cnt_q + 2'd1;
        end else begin
            word_q     <= word_q;
            byte_cnt_q <= byte_cnt_q;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory while holding the CPU, and
// reports an XOR checksum of the words written.
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W         = imem_pkg::ADDR_W,
    parameter int BYTES_PER_WORD = imem_pkg::BYTES_PER_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    loader_state_t     state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d, count_eff_s;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              in_ready_q, mem_we_q, busy_q, done_q;
    logic [ADDR_W-1:0] mem_waddr_q;
    logic [31:0]       mem_wdata_q;
    logic              asm_clr_s, asm_accept_s, asm_full_s;
    logic [31:0]       asm_word_next_s;

    word_assembler #(.BYTES_PER_WORD(BYTES_PER_WORD)) u_asm (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (asm_clr_s),
        .accept_i    (asm_accept_s),
        .byte_i      (in_data),
        .word_next_o (asm_word_next_s),
        .word_full_o (asm_full_s)
    );

    // Next-state logic for the load sequencer, counters and checksum.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        addr_d       = addr_q;
        checksum_d   = checksum_q;
        asm_clr_s    = 1'b0;
        asm_accept_s = 1'b0;
        count_eff_s  = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d    = count_eff_s;
                    addr_d     = {ADDR_W{1'b0}};
                    checksum_d = 32'd0;
                    asm_clr_s  = 1'b1;
                    state_d    = (count_eff_s == {(ADDR_W+1){1'b0}}) ? DONE : COLLECT;
                end else begin
                    state_d = IDLE;
                end
            end
            COLLECT: begin
                asm_accept_s = in_valid && in_ready_q;
                if (asm_full_s) begin
                    state_d = WRITE;
                end else begin
                    state_d = COLLECT;
                end
            end
            WRITE: begin
                checksum_d = checksum_q ^ mem_wdata_q;
                // Stop before incrementing on the last word so the address never wraps.
                if (({1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1}) == count_q) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d = COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and checksum registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= {(ADDR_W+1){1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            checksum_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            checksum_q <= checksum_d;
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            in_ready_q  <= (state_d == COLLECT);
            mem_we_q    <= (state_d == WRITE);
            mem_waddr_q <= (state_d == WRITE) ? addr_q : {ADDR_W{1'b0}};
            mem_wdata_q <= (state_d == WRITE) ? asm_word_next_s : 32'd0;
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign cpu_hold  = busy_q;
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning the instruction-memory word-address width (64 words).
REQ-002 SHALL have parameter BYTES_PER_WORD, default 4, meaning the bytes assembled per instruction word; fixed at 4.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle load request, sampled only in IDLE.
REQ-006 SHALL have port word_count  input  ADDR_W+1  number of words to load, sampled with start.
REQ-007 SHALL have port in_valid  input  1  byte-stream data valid.
REQ-008 SHALL have port in_data  input  8  byte-stream data, most-significant byte of each word first.
REQ-009 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-011 SHALL have port mem_waddr  output  ADDR_W  word address of the write.
REQ-012 SHALL have port mem_wdata  output  32  instruction word written.
REQ-013 SHALL have port cpu_hold  output  1  holds the processor pipeline stalled while loading.
REQ-014 SHALL have port busy  output  1  load in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at load completion.
REQ-016 SHALL have port checksum  output  32  XOR of all words written in the last load; stable from done until the next start.

Function
REQ-017 SHALL implement the states IDLE, COLLECT, WRITE, and DONE.
REQ-018 IDLE: start=1 SHALL latch the effective count, clear the address, byte counter, and checksum, and move to COLLECT; a count of 0 SHALL go directly to DONE.
REQ-019 A word_count above 64 SHALL be clamped to 64.
REQ-020 COLLECT: in_ready=1; a byte SHALL be accepted only when in_valid and in_ready are both 1; each accepted byte SHALL shift into the assembly register, first byte landing in bits [31:24].
REQ-021 Accepting the 4th byte SHALL move the FSM to WRITE on the next edge.
REQ-022 WRITE: lasts exactly 1 cycle, with mem_we=1, mem_waddr equal to the current address, mem_wdata equal to the assembled word, and in_ready=0.
REQ-023 In WRITE, the checksum SHALL XOR with the word and the address SHALL increment.
REQ-024 After WRITE: if the words written equal the count, the FSM SHALL go to DONE; otherwise it SHALL return to COLLECT.
REQ-025 DONE: lasts 1 cycle with done=1, then the FSM SHALL return to IDLE.
REQ-026 Per-word latency: the write strobe SHALL occur 1 cycle after the 4th byte is accepted.
REQ-027 Back-to-back bytes at full rate SHALL give 5 cycles per word.
REQ-028 busy and cpu_hold SHALL be 1 in COLLECT, WRITE, and DONE, and 0 in IDLE.
REQ-029 start outside IDLE SHALL be ignored.
REQ-030 in_valid outside COLLECT SHALL be ignored, with no byte consumed.
REQ-031 The address SHALL never wrap; the last possible write is address 63 with a count of 64.
REQ-032 mem_we SHALL never be asserted outside WRITE.
REQ-033 mem_waddr and mem_wdata SHALL be don't-care when mem_we=0 but SHALL be driven to 0 in IDLE.

Reset
REQ-034 On assertion of reset_n=0, the block SHALL immediately enter IDLE.
REQ-035 During reset, all outputs (in_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, checksum) SHALL be 0, and the counters and assembly register SHALL be 0.
REQ-036 Reset during a load SHALL discard any partial word without a write.
REQ-037 Words already written before a reset during a load SHALL remain in memory.
REQ-038 After deassertion of reset_n, the first start SHALL be accepted on the first clock edge.

Structure
REQ-039 A shared package imem_pkg SHALL hold the state enum loader_state_t, ADDR_W, BYTES_PER_WORD, and IMEM_WORDS=64.
REQ-040 One sub-module, word_assembler, SHALL contain the byte shift register and the 2-bit byte counter, and SHALL provide a word_full flag.
REQ-041 The FSM, address/count counters, and checksum SHALL reside in imem_loader.

Verification
REQ-042 Single word: start with word_count=1 and bytes 20 09 00 02 sent consecutively -> mem_we once at address 0 with data 0x20090002; done 1 cycle later; checksum 0x20090002.
REQ-043 Eight words: word_count=8 with words 0x20090002, 0x10000002, 0x20090005, 0x21290006, 0x20090008, 0x20040000, 0x20050000, 0xac090000 -> writes to addresses 0..7 in order; done after word 7; checksum equal to the XOR of all eight.
REQ-044 Gapped stream: in_valid toggling 1,0,1,0 -> no byte lost or duplicated; in_ready=0 during WRITE, and a byte presented then is accepted in the following COLLECT cycle.
REQ-045 Bounds: word_count=0 -> done after 1 cycle with no mem_we; word_count=100 -> exactly 64 writes, last at address 63.
REQ-046 Reset mid-load: reset_n pulled low after 2 bytes of word 3 -> no write to address 3; all outputs 0; busy=0; a new start succeeds afterward.
REQ-047 Ignored start: start pulsed during COLLECT -> count and address unchanged; load completes normally.
